qk_result_tile_buffer: RTL and testbench
========================================

Name: qk_result_tile_buffer

Overview:
Parametrised successor to the single-bank systolic-array output buffer. Captures per-column result streams from the MATRIX_SIZE x MATRIX_SIZE systolic array into NUM_TILES complete result tiles, organised as a ring of tile slots. Exposes a row-oriented read port with valid, plus explicit tile release, full/empty/occupancy and sticky overflow. Sits between the systolic array outputs and the DDR write-back / softmax consumer.

Parameters:
MATRIX_SIZE, 3, array dimension; rows and columns per tile.
DATA_WIDTH, 18, width of one result element (2*INPUT_WIDTH + clog2(MATRIX_SIZE) for 8-bit operands).
NUM_TILES, 4, number of tile slots in the ring; must be at least 2.
ROW_W, max(1,$clog2(MATRIX_SIZE)), row index width (derived).
CNT_W, $clog2(NUM_TILES+1), occupancy width (derived).

Ports:
clk  in  1  clock
reset_n  in  1  asynchronous active-low reset
clear  in  1  synchronous soft clear of pointers, flags and counters
wr_en  in  MATRIX_SIZE  per-lane write strobe; lane i fills tile row i
wr_data  in  MATRIX_SIZE*DATA_WIDTH  lane i at [(MATRIX_SIZE-i)*DATA_WIDTH-1 -: DATA_WIDTH]
wr_ready  out  1  high when a free tile slot accepts writes
tile_done  out  1  one-cycle pulse when a tile commits
rd_en  in  1  read request for one row of the oldest committed tile
rd_row  in  ROW_W  row to read
rd_data  out  MATRIX_SIZE*DATA_WIDTH  row data, element j at [(MATRIX_SIZE-j)*DATA_WIDTH-1 -: DATA_WIDTH]
rd_valid  out  1  rd_data valid this cycle
rd_release  in  1  frees the oldest committed tile
tiles_avail  out  CNT_W  number of committed, unreleased tiles
full  out  1  tiles_avail == NUM_TILES
empty  out  1  tiles_avail == 0
overflow  out  1  sticky: at least one write was dropped

Behaviour:
- Reset (reset_n low, asynchronous): wr_ptr, rd_ptr, all lane counters and lane-done bits = 0; tiles_avail=0, full=0, empty=1, wr_ready=1, tile_done=0, rd_valid=0, rd_data=0, overflow=0. Storage array is not reset. Reset mid-tile discards the partial tile.
- clear: the same as reset except rd_data is held; it is applied on the clock edge and takes priority over every other input in that cycle.
- Write: wr_ready = !full. When wr_en[i] is high, wr_ready=1 and lane i is not done, the lane element is written to tile[wr_ptr][row i][col cnt[i]] and cnt[i] increments. When cnt[i] reaches MATRIX_SIZE-1 on a write, lane i is marked done.
- Write of a done lane, or any write while wr_ready=0: the data is dropped and overflow is set. overflow is cleared only by reset or clear.
- Commit: on the edge where the last outstanding lane completes, all lane-done bits and counters clear, wr_ptr increments modulo NUM_TILES, tiles_avail increments, and tile_done pulses the next cycle. Lanes may finish in any order or on the same cycle. Writes in the cycle after a commit go to the new slot.
- Read: 1-cycle latency. rd_en with !empty gives rd_data = tile[rd_ptr][rd_row] and rd_valid=1 on the next cycle. rd_en with empty gives rd_valid=0 and rd_data holds. rd_row >= MATRIX_SIZE gives rd_valid=0 and rd_data holds. Otherwise rd_data holds its last value when rd_valid=0.
- Release: rd_release with !empty increments rd_ptr modulo NUM_TILES and decrements tiles_avail. rd_release with empty is ignored.
- Simultaneous commit and release: tiles_avail is unchanged and both pointers advance.
- rd_en with rd_release in the same cycle: the read returns the pre-release tile.
- A write to a freed slot can never overlap a pending read, because wr_ptr is only reused after release.
- full, empty and wr_ready are combinational from the tiles_avail register.

Decomposition:
- Package qk_buf_pkg: lane slice helper function, derived-width constants ROW_W and CNT_W, and the element typedef (logic [DATA_WIDTH-1:0]).
- Sub-module qk_tile_ring_ctrl: wr_ptr, rd_ptr, tiles_avail, full/empty and commit/release arbitration.
- The top level holds the lane counters, the storage array and the read register.

Test Plan:
- MATRIX_SIZE=3, NUM_TILES=2. All lanes write 3 cycles with values row*10+col -> tile_done pulses once, tiles_avail=1; reading rows 0..2 returns {0,1,2},{10,11,12},{20,21,22} with rd_valid 1 cycle after each rd_en.
- Staggered lanes: lane 0 at cycles 0-2, lane 1 at 2-4, lane 2 at 4-6 -> commit on the edge of cycle 6 only; an extra lane-0 write at cycle 3 is dropped and overflow=1.
- Fill 2 tiles -> full=1, wr_ready=0; a wr_en=3'b111 write is dropped, overflow=1, tiles_avail stays 2.
- Commit and rd_release on the same edge with tiles_avail=1 -> tiles_avail stays 1, rd_ptr advances to the new tile, and reading row 0 returns the new data.
- rd_en while empty -> rd_valid=0 and rd_data unchanged. rd_release while empty -> tiles_avail stays 0.
- reset_n pulsed low mid-tile after 2 lane writes, then a full 3-cycle tile -> exactly one tile_done, overflow=0, and the data equals the post-reset writes.

Source files
------------

// File: rtl/qk_buf_pkg.sv
// Shared helpers for the QK result tile buffer: width calculators, lane slicing, element type.
package qk_buf_pkg;

    localparam int unsigned DEF_MATRIX_SIZE = 3;
    localparam int unsigned DEF_DATA_WIDTH  = 18;
    localparam int unsigned DEF_NUM_TILES   = 4;

    typedef logic [DEF_DATA_WIDTH-1:0] elem_t;

    // Row index width; a 1x1 array still needs one bit.
    function automatic int unsigned calc_row_w(input int unsigned ms);
        return (ms > 1) ? $clog2(ms) : 1;
    endfunction

    // Occupancy width: must represent 0..nt inclusive.
    function automatic int unsigned calc_cnt_w(input int unsigned nt);
        return $clog2(nt + 1);
    endfunction

    // Slot pointer width.
    function automatic int unsigned calc_ptr_w(input int unsigned nt);
        return (nt > 1) ? $clog2(nt) : 1;
    endfunction

    // MSB of lane/element idx in a packed row; lane 0 sits at the top.
    function automatic int unsigned lane_msb(input int unsigned idx, input int unsigned ms,
                                             input int unsigned dw);
        return (ms - idx) * dw - 1;
    endfunction

    localparam int unsigned DEF_ROW_W = calc_row_w(DEF_MATRIX_SIZE);
    localparam int unsigned DEF_CNT_W = calc_cnt_w(DEF_NUM_TILES);

endpackage

// File: rtl/qk_tile_ring_ctrl.sv
// Ring bookkeeping for the tile slots: write/read pointers and committed-tile occupancy.
module qk_tile_ring_ctrl
    import qk_buf_pkg::*;
#(
    parameter int unsigned NUM_TILES = 4,
    parameter int unsigned PTR_W     = calc_ptr_w(NUM_TILES),
    parameter int unsigned CNT_W     = calc_cnt_w(NUM_TILES)
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             clear,
    input  logic             commit,
    input  logic             rd_release,
    output logic [PTR_W-1:0] wr_ptr,
    output logic [PTR_W-1:0] rd_ptr,
    output logic [CNT_W-1:0] tiles_avail,
    output logic             full,
    output logic             empty,
    output logic             wr_ready
);

    logic release_ok;

    // Flags come straight from the occupancy register.
    always_comb begin
        full       = (tiles_avail == CNT_W'(NUM_TILES));
        empty      = (tiles_avail == '0);
        wr_ready   = !full;
        release_ok = rd_release && !empty;
    end

    // Pointer advance and occupancy; commit only happens when not full, so no overflow here.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            tiles_avail <= '0;
        end else if (clear) begin
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            tiles_avail <= '0;
        end else begin
            if (commit) begin
                wr_ptr <= (wr_ptr == PTR_W'(NUM_TILES - 1)) ? '0 : wr_ptr + 1'b1;
            end
            if (release_ok) begin
                rd_ptr <= (rd_ptr == PTR_W'(NUM_TILES - 1)) ? '0 : rd_ptr + 1'b1;
            end
            if (commit && !release_ok) begin
                tiles_avail <= tiles_avail + 1'b1;
            end else if (!commit && release_ok) begin
                tiles_avail <= tiles_avail - 1'b1;
            end
        end
    end

endmodule

// File: rtl/qk_result_tile_buffer.sv
// Multi-tile result buffer: collects per-lane systolic outputs into tiles, serves rows of the
// oldest committed tile.
module qk_result_tile_buffer
    import qk_buf_pkg::*;
#(
    parameter int unsigned MATRIX_SIZE = 3,
    parameter int unsigned DATA_WIDTH  = 18,
    parameter int unsigned NUM_TILES   = 4,
    parameter int unsigned ROW_W       = calc_row_w(MATRIX_SIZE),
    parameter int unsigned CNT_W       = calc_cnt_w(NUM_TILES)
) (
    input  logic                              clk,
    input  logic                              reset_n,
    input  logic                              clear,
    input  logic [MATRIX_SIZE-1:0]            wr_en,
    input  logic [MATRIX_SIZE*DATA_WIDTH-1:0] wr_data,
    output logic                              wr_ready,
    output logic                              tile_done,
    input  logic                              rd_en,
    input  logic [ROW_W-1:0]                  rd_row,
    output logic [MATRIX_SIZE*DATA_WIDTH-1:0] rd_data,
    output logic                              rd_valid,
    input  logic                              rd_release,
    output logic [CNT_W-1:0]                  tiles_avail,
    output logic                              full,
    output logic                              empty,
    output logic                              overflow
);

    localparam int unsigned PTR_W = calc_ptr_w(NUM_TILES);

    logic [ROW_W-1:0]       cnt_q [MATRIX_SIZE];
    logic [MATRIX_SIZE-1:0] done_q;
    logic [MATRIX_SIZE-1:0] acc;
    logic [MATRIX_SIZE-1:0] fin;
    logic [MATRIX_SIZE-1:0] drop;
    logic                   commit;
    logic                   rd_ok;
    logic [PTR_W-1:0]       wr_ptr;
    logic [PTR_W-1:0]       rd_ptr;
    logic [MATRIX_SIZE*DATA_WIDTH-1:0] rd_row_vec;

    // Storage is intentionally not reset.
    logic [DATA_WIDTH-1:0] mem [NUM_TILES][MATRIX_SIZE][MATRIX_SIZE];

    qk_tile_ring_ctrl #(
        .NUM_TILES (NUM_TILES),
        .PTR_W     (PTR_W),
        .CNT_W     (CNT_W)
    ) u_ring (
        .clk         (clk),
        .reset_n     (reset_n),
        .clear       (clear),
        .commit      (commit),
        .rd_release  (rd_release),
        .wr_ptr      (wr_ptr),
        .rd_ptr      (rd_ptr),
        .tiles_avail (tiles_avail),
        .full        (full),
        .empty       (empty),
        .wr_ready    (wr_ready)
    );

    // Per-lane accept/drop decode; commit fires when the last open lane finishes.
    always_comb begin
        acc  = '0;
        fin  = '0;
        drop = '0;
        for (int i = 0; i < MATRIX_SIZE; i++) begin
            acc[i]  = wr_en[i] && wr_ready && !done_q[i];
            fin[i]  = acc[i] && (cnt_q[i] == ROW_W'(MATRIX_SIZE - 1));
            drop[i] = wr_en[i] && (!wr_ready || done_q[i]);
        end
        commit = (&(done_q | fin)) && (|fin);
        rd_ok  = rd_en && !empty && (32'(rd_row) < MATRIX_SIZE);
    end

    // Gather the addressed row of the oldest tile, element 0 in the top slice.
    always_comb begin
        rd_row_vec = '0;
        for (int j = 0; j < MATRIX_SIZE; j++) begin
            rd_row_vec[lane_msb(j, MATRIX_SIZE, DATA_WIDTH) -: DATA_WIDTH] = mem[rd_ptr][rd_row][j];
        end
    end

    // Lane column counters and done bits; a done lane parks until the tile commits.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            done_q <= '0;
            for (int i = 0; i < MATRIX_SIZE; i++) cnt_q[i] <= '0;
        end else if (clear || commit) begin
            done_q <= '0;
            for (int i = 0; i < MATRIX_SIZE; i++) cnt_q[i] <= '0;
        end else begin
            for (int i = 0; i < MATRIX_SIZE; i++) begin
                if (fin[i]) begin
                    done_q[i] <= 1'b1;
                end else if (acc[i]) begin
                    cnt_q[i] <= cnt_q[i] + 1'b1;
                end
            end
        end
    end

    // Element writes into the current slot.
    always_ff @(posedge clk) begin
        if (!clear) begin
            for (int i = 0; i < MATRIX_SIZE; i++) begin
                if (acc[i]) begin
                    mem[wr_ptr][i][cnt_q[i]] <= wr_data[lane_msb(i, MATRIX_SIZE, DATA_WIDTH) -: DATA_WIDTH];
                end
            end
        end
    end

    // Read register; data holds whenever no valid read is issued (including on clear).
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rd_valid <= 1'b0;
            rd_data  <= '0;
        end else if (clear) begin
            rd_valid <= 1'b0;
        end else begin
            rd_valid <= rd_ok;
            if (rd_ok) rd_data <= rd_row_vec;
        end
    end

    // Commit pulse and sticky drop flag.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            tile_done <= 1'b0;
            overflow  <= 1'b0;
        end else if (clear) begin
            tile_done <= 1'b0;
            overflow  <= 1'b0;
        end else begin
            tile_done <= commit;
            if (|drop) overflow <= 1'b1;
        end
    end

endmodule

// File: tb/tb_qk_result_tile_buffer.sv
// Directed bench for qk_result_tile_buffer (3x3 tiles, 2 slots) with a read scoreboard.
module tb_qk_result_tile_buffer;

    localparam int unsigned MS = 3;
    localparam int unsigned DW = 18;
    localparam int unsigned NT = 2;
    localparam int unsigned RW = 2;
    localparam int unsigned CW = 2;

    logic            clk = 1'b0;
    logic            reset_n = 1'b0;
    logic            clear = 1'b0;
    logic [MS-1:0]   wr_en = '0;
    logic [MS*DW-1:0] wr_data = '0;
    logic            wr_ready;
    logic            tile_done;
    logic            rd_en = 1'b0;
    logic [RW-1:0]   rd_row = '0;
    logic [MS*DW-1:0] rd_data;
    logic            rd_valid;
    logic            rd_release = 1'b0;
    logic [CW-1:0]   tiles_avail;
    logic            full;
    logic            empty;
    logic            overflow;

    int checks = 0;
    int errors = 0;
    int done_cnt = 0;
    logic [MS*DW-1:0] sb [$];

    qk_result_tile_buffer #(
        .MATRIX_SIZE (MS),
        .DATA_WIDTH  (DW),
        .NUM_TILES   (NT)
    ) dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .clear       (clear),
        .wr_en       (wr_en),
        .wr_data     (wr_data),
        .wr_ready    (wr_ready),
        .tile_done   (tile_done),
        .rd_en       (rd_en),
        .rd_row      (rd_row),
        .rd_data     (rd_data),
        .rd_valid    (rd_valid),
        .rd_release  (rd_release),
        .tiles_avail (tiles_avail),
        .full        (full),
        .empty       (empty),
        .overflow    (overflow)
    );

    always #5 clk = ~clk;

    function automatic logic [MS*DW-1:0] pack(input int a, input int b, input int c);
        return {DW'(a), DW'(b), DW'(c)};
    endfunction

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        if (tile_done === 1'b1) done_cnt++;
    endtask

    task automatic wr(input logic [MS-1:0] en, input logic [MS*DW-1:0] d, input bit rel);
        wr_en = en;
        wr_data = d;
        rd_release = rel;
        step();
        wr_en = '0;
        wr_data = '0;
        rd_release = 1'b0;
    endtask

    // Full tile, all lanes in lockstep; element (r,c) = base + r*10 + c.
    task automatic wr_tile(input int base, input bit rel_last);
        for (int c = 0; c < MS; c++) begin
            wr(3'b111, pack(base + c, base + 10 + c, base + 20 + c), (c == MS - 1) && rel_last);
        end
    endtask

    // Read one row; expectation enters the scoreboard when the request is driven.
    task automatic do_read(input int row, input logic [MS*DW-1:0] exp, input bit rel);
        rd_en = 1'b1;
        rd_row = RW'(row);
        rd_release = rel;
        sb.push_back(exp);
        step();
        rd_en = 1'b0;
        rd_release = 1'b0;
        check("rd_valid", 64'(rd_valid), 64'd1);
        if (sb.size() > 0) check("rd_data", 64'(rd_data), 64'(sb.pop_front()));
    endtask

    task automatic row_exp(input int base, input int r, output logic [MS*DW-1:0] v);
        v = pack(base + r * 10, base + r * 10 + 1, base + r * 10 + 2);
    endtask

    initial begin
        logic [MS*DW-1:0] e;
        #12;
        reset_n = 1'b1;
        step();
        check("rst_avail", 64'(tiles_avail), 64'd0);
        check("rst_full", 64'(full), 64'd0);
        check("rst_empty", 64'(empty), 64'd1);
        check("rst_wr_ready", 64'(wr_ready), 64'd1);
        check("rst_tile_done", 64'(tile_done), 64'd0);
        check("rst_rd_valid", 64'(rd_valid), 64'd0);
        check("rst_rd_data", 64'(rd_data), 64'd0);
        check("rst_overflow", 64'(overflow), 64'd0);

        // Basic tile
        done_cnt = 0;
        wr_tile(0, 1'b0);
        check("t1_avail", 64'(tiles_avail), 64'd1);
        step();
        check("t1_done_once", 64'(done_cnt), 64'd1);
        for (int r = 0; r < MS; r++) begin
            row_exp(0, r, e);
            do_read(r, e, 1'b0);
        end
        wr('0, '0, 1'b1);
        check("t1_release", 64'(tiles_avail), 64'd0);

        // Staggered lanes plus a dropped extra lane-0 write
        wr(3'b001, pack(100, 0, 0), 1'b0);
        wr(3'b001, pack(101, 0, 0), 1'b0);
        wr(3'b011, pack(102, 110, 0), 1'b0);
        wr(3'b011, pack(999, 111, 0), 1'b0);
        check("stag_overflow", 64'(overflow), 64'd1);
        wr(3'b110, pack(0, 112, 120), 1'b0);
        wr(3'b100, pack(0, 0, 121), 1'b0);
        check("stag_no_early", 64'(tiles_avail), 64'd0);
        wr(3'b100, pack(0, 0, 122), 1'b0);
        check("stag_avail", 64'(tiles_avail), 64'd1);
        check("stag_done", 64'(tile_done), 64'd1);
        do_read(1, pack(110, 111, 112), 1'b0);
        do_read(0, pack(100, 101, 102), 1'b0);

        // Soft clear holds rd_data
        clear = 1'b1;
        step();
        clear = 1'b0;
        check("clr_avail", 64'(tiles_avail), 64'd0);
        check("clr_overflow", 64'(overflow), 64'd0);
        check("clr_empty", 64'(empty), 64'd1);
        check("clr_rd_valid", 64'(rd_valid), 64'd0);
        check("clr_rd_data", 64'(rd_data), 64'(pack(100, 101, 102)));

        // Fill both slots, then a dropped write while full
        wr_tile(200, 1'b0);
        wr_tile(300, 1'b0);
        check("full_avail", 64'(tiles_avail), 64'd2);
        check("full_flag", 64'(full), 64'd1);
        check("full_wr_ready", 64'(wr_ready), 64'd0);
        wr(3'b111, pack(1, 2, 3), 1'b0);
        check("full_overflow", 64'(overflow), 64'd1);
        check("full_avail_hold", 64'(tiles_avail), 64'd2);
        row_exp(200, 2, e);
        do_read(2, e, 1'b0);
        wr('0, '0, 1'b1);
        check("rel_avail", 64'(tiles_avail), 64'd1);
        row_exp(300, 0, e);
        do_read(0, e, 1'b0);

        // Commit and release on the same edge
        wr_tile(400, 1'b1);
        check("cr_avail", 64'(tiles_avail), 64'd1);
        check("cr_done", 64'(tile_done), 64'd1);
        row_exp(400, 0, e);
        do_read(0, e, 1'b1);
        check("rdrel_avail", 64'(tiles_avail), 64'd0);

        // Empty read and release
        rd_en = 1'b1;
        rd_row = 2'd1;
        step();
        rd_en = 1'b0;
        check("empty_rd_valid", 64'(rd_valid), 64'd0);
        check("empty_rd_data", 64'(rd_data), 64'(pack(400, 401, 402)));
        wr('0, '0, 1'b1);
        check("empty_rel", 64'(tiles_avail), 64'd0);

        // Reset mid-tile
        done_cnt = 0;
        wr(3'b111, pack(500, 510, 520), 1'b0);
        wr(3'b111, pack(501, 511, 521), 1'b0);
        reset_n = 1'b0;
        #2;
        reset_n = 1'b1;
        wr_tile(600, 1'b0);
        step();
        step();
        check("rst_mid_done", 64'(done_cnt), 64'd1);
        check("rst_mid_overflow", 64'(overflow), 64'd0);
        check("rst_mid_avail", 64'(tiles_avail), 64'd1);
        for (int r = 0; r < MS; r++) begin
            row_exp(600, r, e);
            do_read(r, e, 1'b0);
        end

        // Out-of-range row with a tile available
        rd_en = 1'b1;
        rd_row = 2'd3;
        step();
        rd_en = 1'b0;
        check("oor_rd_valid", 64'(rd_valid), 64'd0);
        row_exp(600, 2, e);
        check("oor_rd_data", 64'(rd_data), 64'(e));

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
